uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, serial baud rate.
REQ-003 SHALL have parameter GAP_BYTES, default 4, inter-byte timeout in character times (10 bits each).
REQ-004 SHALL have parameter HDR_BYTE, default 8'hA5, frame start byte.
REQ-005 SHALL have port sys_clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port recv_done  input  1  one-cycle strobe from the UART receiver: byte valid.
REQ-008 SHALL have port recv_data  input  8  received byte, valid when recv_done=1.
REQ-009 SHALL have port pkt_done  output  1  one-cycle strobe: good frame complete.
REQ-010 SHALL have port pkt_cmd  output  8  command byte of the current/last frame.
REQ-011 SHALL have port pkt_len  output  4  payload length of the current/last frame.
REQ-012 SHALL have port pld_we  output  1  one-cycle payload write strobe.
REQ-013 SHALL have port pld_addr  output  4  payload byte index, 0-based.
REQ-014 SHALL have port pld_data  output  8  payload byte.
REQ-015 SHALL have port pkt_err  output  1  one-cycle strobe: frame aborted.
REQ-016 SHALL have port err_code  output  2  abort cause, valid with pkt_err: 1=length>15, 2=timeout, 3=checksum.

Function
REQ-017 Frame format SHALL be: HDR_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK = (CMD+LEN+sum of payload) mod 256.
REQ-018 FSM SHALL have states IDLE, CMD, LEN, PLD, CHK, and SHALL change state only on recv_done or on timeout.
REQ-019 In IDLE, recv_data==HDR_BYTE SHALL go to CMD; any other byte SHALL be dropped silently.
REQ-020 In CMD, the byte SHALL be latched into pkt_cmd and seed the checksum accumulator; next state LEN.
REQ-021 In LEN, recv_data[7:4]!=0 SHALL pulse pkt_err with err_code=1 and return to IDLE; otherwise pkt_len SHALL be latched, and the FSM SHALL go to PLD (len>0) or CHK (len=0).
REQ-022 In PLD, each byte SHALL produce pld_we=1 for one cycle, registered 1 cycle after recv_done, with pld_addr=index and pld_data=byte; after byte index pkt_len-1 the FSM SHALL go to CHK.
REQ-023 HDR_BYTE values inside CMD/LEN/PLD/CHK SHALL be treated as ordinary data.
REQ-024 In CHK, a match SHALL pulse pkt_done and a mismatch SHALL pulse pkt_err with err_code=3, 1 cycle after recv_done; both cases return to IDLE.
REQ-025 The timeout counter SHALL clear on every recv_done and count while not in IDLE; reaching GAP_BYTES*10*CLK_FREQ/UART_BPS cycles SHALL pulse pkt_err with err_code=2 and return to IDLE.
REQ-026 When recv_done coincides with timeout expiry, the byte SHALL win: no timeout error, counter restarts.
REQ-027 pkt_done and pkt_err SHALL never assert in the same cycle; each SHALL be exactly one cycle wide.
REQ-028 pkt_cmd/pkt_len SHALL hold their values until the next frame's CMD/LEN byte.
REQ-029 Timeout counter width SHALL be sized by $clog2 of the limit; the checksum SHALL be an 8-bit wrap-around sum.

Reset
REQ-030 On sys_rst_n=0 at a clock edge: FSM=IDLE, counters/accumulator=0, all outputs=0.
REQ-031 Reset mid-frame SHALL discard the partial frame without pkt_err; the first byte after release is parsed from IDLE.

Structure
REQ-032 State encodings, err_code constants (ERR_LEN=1, ERR_TMO=2, ERR_CHK=3) and MAX_LEN=15 SHALL live in a shared package uart_pkg.
REQ-033 The design SHALL be a single module, no sub-modules; it instantiates downstream of uart_recv.

Verification
REQ-034 Bytes A5 01 02 10 20 33 -> pld_we at addr0=10, addr1=20; pkt_done once; pkt_cmd=01; pkt_len=2.
REQ-035 Bytes A5 07 00 07 -> pkt_done, no pld_we, pkt_len=0.
REQ-036 Bytes A5 01 01 FF 00 (expected CHK 01) -> pkt_err, err_code=3, no pkt_done.
REQ-037 Bytes A5 02 10 -> pkt_err, err_code=1 on LEN byte; then A5 02 00 02 -> pkt_done.
REQ-038 Bytes A5 01 then silence -> pkt_err, err_code=2 exactly 17361 cycles after the last recv_done (defaults); a recv_done landing on the expiry cycle -> no error.
REQ-039 Bytes 55 A5 03 01 A5 A9, with reset asserted after A5 03 01 -> no pkt_done, no pkt_err; the next valid frame parses correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART command-frame parser: FSM encodings, abort causes,
// frame limits and the inter-byte timeout calculation.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_LEN  = 3'd2;
  localparam state_t ST_PLD  = 3'd3;
  localparam state_t ST_CHK  = 3'd4;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_LEN  = 2'd1;
  localparam err_code_t ERR_TMO  = 2'd2;
  localparam err_code_t ERR_CHK  = 2'd3;

  localparam int MAX_LEN = 15;

  // Gap limit in clock cycles; 64-bit math so large clock rates do not overflow.
  function automatic int calc_tmo_limit(input int gap_bytes, input int clk_freq,
                                        input int uart_bps);
    longint prod;
    prod = longint'(gap_bytes) * 64'sd10 * longint'(clk_freq);
    return int'(prod / longint'(uart_bps));
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses HDR/CMD/LEN/payload/CHK frames from a byte-strobe UART receiver, streaming
// payload bytes out as indexed writes and flagging frame completion or abort cause.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         UART_BPS  = 115200,
  parameter int         GAP_BYTES = 4,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       recv_done,
  input  logic [7:0] recv_data,
  output logic       pkt_done,
  output logic [7:0] pkt_cmd,
  output logic [3:0] pkt_len,
  output logic       pld_we,
  output logic [3:0] pld_addr,
  output logic [7:0] pld_data,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int TMO_LIMIT = calc_tmo_limit(GAP_BYTES, CLK_FREQ, UART_BPS);
  localparam int TMO_W     = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

  state_t           state_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [7:0]       chk_acc_reg;
  logic [3:0]       pld_idx_reg;
  logic             tmo_hit;

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign tmo_hit = (state_reg != ST_IDLE) && !recv_done && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg   <= ST_IDLE;
      tmo_cnt_reg <= '0;
      chk_acc_reg <= '0;
      pld_idx_reg <= '0;
      pkt_done    <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pld_we      <= 1'b0;
      pld_addr    <= '0;
      pld_data    <= '0;
      pkt_err     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      pld_we   <= 1'b0;

      if (recv_done || state_reg == ST_IDLE || tmo_hit) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end

      if (tmo_hit) begin
        pkt_err   <= 1'b1;
        err_code  <= ERR_TMO;
        state_reg <= ST_IDLE;
      end else if (recv_done) begin
        case (state_reg)
          ST_IDLE: begin
            if (recv_data == HDR_BYTE) begin
              state_reg <= ST_CMD;
            end
          end
          ST_CMD: begin
            pkt_cmd     <= recv_data;
            chk_acc_reg <= recv_data;
            state_reg   <= ST_LEN;
          end
          ST_LEN: begin
            if (recv_data > 8'(MAX_LEN)) begin
              pkt_err   <= 1'b1;
              err_code  <= ERR_LEN;
              state_reg <= ST_IDLE;
            end else begin
              pkt_len     <= recv_data[3:0];
              chk_acc_reg <= chk_acc_reg + recv_data;
              pld_idx_reg <= '0;
              state_reg   <= (recv_data[3:0] == 4'd0) ? ST_CHK : ST_PLD;
            end
          end
          ST_PLD: begin
            pld_we      <= 1'b1;
            pld_addr    <= pld_idx_reg;
            pld_data    <= recv_data;
            chk_acc_reg <= chk_acc_reg + recv_data;
            if (pld_idx_reg == pkt_len - 4'd1) begin
              state_reg <= ST_CHK;
            end else begin
              pld_idx_reg <= pld_idx_reg + 4'd1;
            end
          end
          ST_CHK: begin
            if (recv_data == chk_acc_reg) begin
              pkt_done <= 1'b1;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_CHK;
            end
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of frames with hand-derived outcomes,
// an event scoreboard fed by a frame model, plus timeout and mid-frame reset sequences.
module tb_uart_cmd_parser;

  localparam int LIMIT  = 17361;  // 4*10*50e6/115200 with default parameters
  localparam int EV_PLD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR = 2;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       recv_done;
  logic [7:0] recv_data;
  logic       pkt_done;
  logic [7:0] pkt_cmd;
  logic [3:0] pkt_len;
  logic       pld_we;
  logic [3:0] pld_addr;
  logic [7:0] pld_data;
  logic       pkt_err;
  logic [1:0] err_code;

  uart_cmd_parser dut (
    .sys_clk  (clk),
    .sys_rst_n(sys_rst_n),
    .recv_done(recv_done),
    .recv_data(recv_data),
    .pkt_done (pkt_done),
    .pkt_cmd  (pkt_cmd),
    .pkt_len  (pkt_len),
    .pld_we   (pld_we),
    .pld_addr (pld_addr),
    .pld_data (pld_data),
    .pkt_err  (pkt_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         n;
    logic [7:0] b [0:19];
    logic       exp_done;
    logic [1:0] exp_err;
    int         exp_we;
    logic [7:0] exp_cmd;
    logic [3:0] exp_len;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;
  int obs_done = 0;
  int obs_err  = 0;
  int obs_we   = 0;
  logic [1:0] obs_code = 2'd0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  // Frame model state
  int         m_state = 0;
  logic [7:0] m_acc;
  logic [3:0] m_len;
  logic [3:0] m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [3:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_state)
      0: if (b == 8'hA5) m_state = 1;
      1: begin m_acc = b; m_state = 2; end
      2: begin
        if (b[7:4] != 4'd0) begin
          push_ev(EV_ERR, 4'd0, 8'd1);
          m_state = 0;
        end else begin
          m_len = b[3:0];
          m_acc = m_acc + b;
          m_idx = 4'd0;
          m_state = (b[3:0] == 4'd0) ? 4 : 3;
        end
      end
      3: begin
        push_ev(EV_PLD, m_idx, b);
        m_acc = m_acc + b;
        if (m_idx == m_len - 4'd1) m_state = 4;
        else m_idx = m_idx + 4'd1;
      end
      default: begin
        if (b == m_acc) push_ev(EV_DONE, 4'd0, 8'd0);
        else push_ev(EV_ERR, 4'd0, 8'd3);
        m_state = 0;
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    recv_done = 1'b1;
    recv_data = b;
    @(posedge clk);
    @(negedge clk);
    recv_done = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_obs();
    obs_done = 0;
    obs_err  = 0;
    obs_we   = 0;
    obs_code = 2'd0;
  endtask

  task automatic add_vec(input logic [63:0] bytes, input int n, input logic exp_done,
                         input logic [1:0] exp_err, input int exp_we,
                         input logic [7:0] exp_cmd, input logic [3:0] exp_len);
    vec_t v;
    v.n = n;
    for (int k = 0; k < 20; k++) v.b[k] = 8'h00;
    for (int k = 0; k < 8; k++) v.b[k] = bytes[63-8*k -: 8];
    v.exp_done = exp_done;
    v.exp_err  = exp_err;
    v.exp_we   = exp_we;
    v.exp_cmd  = exp_cmd;
    v.exp_len  = exp_len;
    vecs.push_back(v);
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    ev_t e;
    check("done_err_exclusive", {31'd0, pkt_done & pkt_err}, 0);
    if (pkt_done) check("done_width", {31'd0, prev_done}, 0);
    if (pkt_err)  check("err_width", {31'd0, prev_err}, 0);
    prev_done = pkt_done;
    prev_err  = pkt_err;
    if (pld_we) begin
      obs_we++;
      if (exp_q.size() == 0) check("unexpected_pld_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pld_kind", e.kind, EV_PLD);
        check("pld_addr", {28'd0, pld_addr}, {28'd0, e.addr});
        check("pld_data", {24'd0, pld_data}, {24'd0, e.data});
      end
    end
    if (pkt_done) begin
      obs_done++;
      if (exp_q.size() == 0) check("unexpected_pkt_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("done_kind", e.kind, EV_DONE);
      end
    end
    if (pkt_err) begin
      obs_err++;
      obs_code = err_code;
      if (exp_q.size() == 0) check("unexpected_pkt_err", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("err_kind", e.kind, EV_ERR);
        check("err_code", {30'd0, err_code}, {24'd0, e.data});
      end
    end
  end

  initial begin
    vec_t v;
    int   k;
    logic [7:0] s;

    recv_done = 1'b0;
    recv_data = 8'h00;
    sys_rst_n = 1'b0;

    // Frames: expected outcomes derived by hand from the frame format
    add_vec(64'hA5_01_02_10_20_33_00_00, 6, 1'b1, 2'd0, 2, 8'h01, 4'd2);
    add_vec(64'hA5_07_00_07_00_00_00_00, 4, 1'b1, 2'd0, 0, 8'h07, 4'd0);
    add_vec(64'hA5_01_01_FF_00_00_00_00, 5, 1'b0, 2'd3, 1, 8'h01, 4'd1);
    add_vec(64'hA5_02_10_00_00_00_00_00, 3, 1'b0, 2'd1, 0, 8'h02, 4'd1);
    add_vec(64'hA5_02_00_02_00_00_00_00, 4, 1'b1, 2'd0, 0, 8'h02, 4'd0);
    add_vec(64'h55_A5_A5_01_A5_4B_00_00, 6, 1'b1, 2'd0, 1, 8'hA5, 4'd1);
    // Maximum length: payload 0..14 sums to 0x69, CHK = 03+0F+69 = 7B
    add_vec(64'hA5_03_0F_00_00_00_00_00, 19, 1'b1, 2'd0, 15, 8'h03, 4'd15);
    s = 8'h03 + 8'h0F;
    for (int i = 0; i < 15; i++) begin
      vecs[6].b[3+i] = 8'(i);
      s = s + 8'(i);
    end
    vecs[6].b[18] = s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pkt_done", {31'd0, pkt_done}, 0);
    check("rst_pkt_err", {31'd0, pkt_err}, 0);
    check("rst_pld_we", {31'd0, pld_we}, 0);
    check("rst_pkt_cmd", {24'd0, pkt_cmd}, 0);
    check("rst_pkt_len", {28'd0, pkt_len}, 0);
    check("rst_outputs_misc", {18'd0, pld_addr, pld_data, err_code}, 0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      clear_obs();
      for (k = 0; k < v.n; k++) begin
        send_byte(v.b[k]);
        repeat (2) @(negedge clk);
      end
      drain("vec_drain");
      check("vec_done_cnt", obs_done, {31'd0, v.exp_done});
      check("vec_err_cnt", obs_err, (v.exp_err != 2'd0) ? 1 : 0);
      check("vec_err_code", {30'd0, obs_code}, {30'd0, v.exp_err});
      check("vec_we_cnt", obs_we, v.exp_we);
      check("vec_pkt_cmd", {24'd0, pkt_cmd}, {24'd0, v.exp_cmd});
      check("vec_pkt_len", {28'd0, pkt_len}, {28'd0, v.exp_len});
      $display("frame %0d: %0d bytes, done=%0d err=%0d code=%0d we=%0d cmd=%h len=%0d",
               i, v.n, obs_done, obs_err, obs_code, obs_we, pkt_cmd, pkt_len);
    end

    // Silence after CMD: timeout exactly LIMIT cycles after the last byte's sampling edge
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h01);
    push_ev(EV_ERR, 4'd0, 8'd2);
    m_state = 0;
    k = 0;
    for (int i = 0; i < LIMIT + 50; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (pkt_err) break;
    end
    check("tmo_latency", k, LIMIT);
    check("tmo_code", {30'd0, err_code}, 2);
    drain("tmo_drain");
    $display("timeout: pkt_err after %0d cycles, code=%0d", k, err_code);

    // Byte landing on the expiry cycle wins; frame then completes normally
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (LIMIT - 1) @(negedge clk);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    send_byte(8'h01);
    drain("coincide_drain");
    check("coincide_no_err", obs_err, 0);
    check("coincide_done", obs_done, 1);
    $display("coincident byte: err=%0d done=%0d", obs_err, obs_done);

    // Reset mid-frame discards the partial frame silently
    clear_obs();
    send_byte(8'h55);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h01);
    sys_rst_n = 1'b0;
    m_state = 0;
    repeat (3) @(negedge clk);
    check("midrst_pkt_cmd", {24'd0, pkt_cmd}, 0);
    check("midrst_pkt_len", {28'd0, pkt_len}, 0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'hA9);
    send_byte(8'h00);
    send_byte(8'hA9);
    drain("midrst_drain");
    check("midrst_no_err", obs_err, 0);
    check("midrst_done", obs_done, 1);
    check("midrst_cmd_after", {24'd0, pkt_cmd}, 32'hA9);
    $display("mid-frame reset: err=%0d done=%0d cmd=%h", obs_err, obs_done, pkt_cmd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
